sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO: the next-generation buffer for streaming 16-bit sample data between producer and consumer logic in the same clock domain. Generalises width, depth and thresholds; adds occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags, synchronous flush, and an optional first-word-fall-through read mode. Sits between a data source (e.g. ADC capture, UART RX) and a consumer that reads at its own pace.

## Interface
- DATA_W, 16, data word width (≥1)
- DEPTH, 10, number of entries (≥2; need not be a power of two)
- AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH
- Derived: PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request (FWFT mode: acknowledge of head word)
- dout  out  DATA_W  read data
- dout_valid  out  1  dout holds a newly read / head word
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_THRESH=0), overflow=0, underflow=0, dout=0, dout_valid=0, wptr=rptr=0. Memory contents not reset.
- Write accepted iff wr_en && !full (flag value at start of cycle). Accepted write stores din at mem[wptr]; wptr advances, wrapping DEPTH-1 → 0.
- Read accepted iff rd_en && !empty. rptr advances with same wrap rule. Memory entry is not zeroed on read.
- wr_en while full: write dropped, overflow set. rd_en while empty: nothing read, underflow set. Both remain set until rst or clr.
- count: +1 write only, −1 read only, unchanged on simultaneous accepted read+write (legal at any non-empty, non-full occupancy). Full + wr_en + rd_en: read accepted, write rejected, overflow set. Empty + both: write accepted, underflow set.
- All flags derived from count register: full = (count==DEPTH), empty = (count==0); update in same cycle as count.
- clr: wptr, rptr, count → 0, overflow/underflow → 0, dout_valid → 0; dominates wr_en/rd_en in same cycle; dout holds value.
- rst asserted mid-operation: immediate return to reset values; in-flight write lost.

## Timing
- Standard mode: accepted read at edge N → dout and dout_valid=1 after edge N+1... precisely, dout registered at edge N, valid for cycle N+1; dout_valid is a 1-cycle pulse per accepted read; dout holds otherwise.
- Write-to-empty-deassert latency: 1 cycle (empty falls after the edge that accepts the write).
- Write-to-read data latency (standard mode): write at edge N, earliest read request at edge N+1, data on dout after edge N+1.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. dout = mem[rptr] whenever !empty; dout_valid = !empty (combinational from count); rd_en pops the shown word; write-to-dout latency 1 cycle; dout undefined-but-stable when empty.
- Undefined: standard registered read as in Timing.

## Structure
- Package sync_fifo_pkg: clog2 function, default DATA_W/DEPTH constants, pointer-increment-with-wrap function.
- One sub-module sync_fifo_mem: DEPTH×DATA_W simple dual-port array, one synchronous write port, one asynchronous read address port (registered outside in standard mode).
- Control (pointers, count, flags, error bits) in sync_fifo top.

## Test plan
- Reset then write 10 words 0x0001..0x000A (DEPTH=10) -> full=1 after 10th edge, count=10, almost_full=1 from count=8; 11th write -> overflow=1, count stays 10.
- Read all 10 -> dout sequence 0x0001..0x000A, one dout_valid pulse each, empty=1 at end; extra rd_en -> underflow=1, dout unchanged.
- Fill 5, then simultaneous wr/rd for 20 cycles -> count stays 5, pointers wrap twice, data order preserved.
- Full + wr_en + rd_en -> head word read, write dropped, count=9, overflow=1.
- Fill 6, assert clr with wr_en=1 -> count=0, empty=1, errors cleared, din not stored; then rst pulse mid-write -> all outputs at reset values.
- SYNC_FIFO_FWFT_EN: write 0x00AB to empty FIFO -> dout=0x00AB, dout_valid=1 one cycle later without rd_en; rd_en -> empty=1, dout_valid=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the sync_fifo slice
package sync_fifo_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  // Wraps at DEPTH-1 so non-power-of-two depths work
  function automatic int ptr_next(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read
module sync_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 10,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  logic [PTR_W-1:0] wptr, rptr;
  logic [DATA_W-1:0] rdata;
  logic wr_ok, rd_ok;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CNT_W'(AF_THRESH);
  assign almost_empty = count <= CNT_W'(AE_THRESH);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk(clk),
    .we(wr_ok && !clr),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= PTR_W'(ptr_next(int'(wptr), DEPTH));
      if (rd_ok) rptr <= PTR_W'(ptr_next(int'(rptr), DEPTH));
      count <= (wr_ok && !rd_ok) ? count + CNT_W'(1) :
               (rd_ok && !wr_ok) ? count - CNT_W'(1) : count;
      overflow <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign dout = rdata;
  assign dout_valid = !empty;
`else
  // dout holds across clr; only the valid pulse is cancelled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else if (clr) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) dout <= rdata;
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH=10, DATA_W=16)
module tb_sync_fifo;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int checks = 0, failures = 0;
  logic [15:0] q[$];
  logic [15:0] exp_d;

  sync_fifo dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_dv", 32'(dout_valid), 0);
    rst = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    wr_en = 1'b1; din = 16'h00AB;
    step();
    wr_en = 1'b0;
    chk("fwft_dout", 32'(dout), 32'h00AB);
    chk("fwft_dv", 32'(dout_valid), 1);
    chk("fwft_empty", 32'(empty), 0);
    step();
    chk("fwft_hold_dv", 32'(dout_valid), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(empty), 1);
    chk("fwft_pop_dv", 32'(dout_valid), 0);
`else
    chk("rst_dout", 32'(dout), 0);
    // fill 1..10, almost_full from count 8
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1; din = 16'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 8) ? 1 : 0);
    end
    chk("fill_full", 32'(full), 1);
    din = 16'h00FF;
    step();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 10);
    for (int i = 1; i <= 10; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_dout", 32'(dout), 32'(i));
      chk("drain_dv", 32'(dout_valid), 1);
    end
    rd_en = 1'b0;
    step();
    chk("drain_dv_pulse", 32'(dout_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_set", 32'(underflow), 1);
    chk("unf_dout_hold", 32'(dout), 32'h000A);
    chk("unf_dv", 32'(dout_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);
    // steady state at 5 entries, pointers wrap twice
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 16'h0100 + 16'(i); q.push_back(din);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 16'h0200 + 16'(k); q.push_back(din);
      exp_d = q.pop_front();
      step();
      chk("stream_count", 32'(count), 5);
      chk("stream_dout", 32'(dout), 32'(exp_d));
    end
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 16'h0300 + 16'(i); q.push_back(din);
      step();
    end
    chk("refill_full", 32'(full), 1);
    wr_en = 1'b1; rd_en = 1'b1; din = 16'hDEAD;
    exp_d = q.pop_front();
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("fullrw_dout", 32'(dout), 32'(exp_d));
    chk("fullrw_count", 32'(count), 9);
    chk("fullrw_ovf", 32'(overflow), 1);
    for (int i = 0; i < 9; i++) begin
      rd_en = 1'b1;
      exp_d = q.pop_front();
      step();
      chk("fullrw_drain", 32'(dout), 32'(exp_d));
    end
    step();
    chk("fullrw_empty", 32'(empty), 1);
    step();
    rd_en = 1'b0;
    chk("unf_again", 32'(underflow), 1);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; din = 16'h0400 + 16'(i);
      step();
    end
    chk("fill6_count", 32'(count), 6);
    clr = 1'b1; din = 16'hBEEF;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_errs", 32'({overflow, underflow}), 0);
    chk("clr_dv", 32'(dout_valid), 0);
    wr_en = 1'b1; din = 16'h0055;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_clr_dout", 32'(dout), 32'h0055);
    wr_en = 1'b1; din = 16'h0077;
    step();
    chk("pre_rst_count", 32'(count), 1);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_dv", 32'(dout_valid), 0);
    step();
    wr_en = 1'b0; rst = 1'b0;
    step();
    chk("arst_hold_count", 32'(count), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
